// File: rtl/byte_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : byte_reg_arbiter
// Purpose  : Two-port round-robin write arbiter owning a 16-bit byte-enabled
//            register; disjoint-lane requests are merged in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module byte_reg_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_val,
  output logic        req0_rdy,
  input  logic [1:0]  req0_en,
  input  logic [15:0] req0_d,
  input  logic        req1_val,
  output logic        req1_rdy,
  input  logic [1:0]  req1_en,
  input  logic [15:0] req1_d,
  output logic [15:0] q,
  output logic        prio
);

  logic        conflict;
  logic        gnt0;
  logic        gnt1;
  logic        prio_d;
  logic        prio_q;
  logic [15:0] data_d;
  logic [15:0] data_q;

  // A zero-enable request has no overlapping lanes, so it can never conflict.
  always_comb begin
    conflict = req0_val & req1_val & (|(req0_en & req1_en));
    gnt0     = reset & req0_val & (~conflict | ~prio_q);
    gnt1     = reset & req1_val & (~conflict |  prio_q);
    prio_d   = conflict ? ~prio_q : prio_q;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] lane_d;
      // Both grants never enable the same lane, so the order here is moot.
      always_comb begin
        lane_d = data_q[gi*8 +: 8];
        if (gnt0 && req0_en[gi]) begin
          lane_d = req0_d[gi*8 +: 8];
        end else if (gnt1 && req1_en[gi]) begin
          lane_d = req1_d[gi*8 +: 8];
        end
      end
      assign data_d[gi*8 +: 8] = lane_d;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= 16'h0000;
      prio_q <= 1'b0;
    end else begin
      data_q <= data_d;
      prio_q <= prio_d;
    end
  end

  assign req0_rdy = gnt0;
  assign req1_rdy = gnt1;
  assign q        = data_q;
  assign prio     = prio_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_reg_arbiter
// Purpose  : Directed bench with a lane-level behavioural model for
//            byte_reg_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_reg_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_val = 1'b0;
  logic        req0_rdy;
  logic [1:0]  req0_en = 2'b00;
  logic [15:0] req0_d = 16'h0000;
  logic        req1_val = 1'b0;
  logic        req1_rdy;
  logic [1:0]  req1_en = 2'b00;
  logic [15:0] req1_d = 16'h0000;
  logic [15:0] q;
  logic        prio;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_q = 16'h0000;
  logic        m_prio = 1'b0;

  byte_reg_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req0_val (req0_val),
    .req0_rdy (req0_rdy),
    .req0_en  (req0_en),
    .req0_d   (req0_d),
    .req1_val (req1_val),
    .req1_rdy (req1_rdy),
    .req1_en  (req1_en),
    .req1_d   (req1_d),
    .q        (q),
    .prio     (prio)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requesters the rules admit: returns {grant1, grant0}.
  function automatic logic [1:0] grants(input logic v0, input logic v1,
                                        input logic [1:0] e0, input logic [1:0] e1,
                                        input logic p);
    logic clash;
    clash = v0 && v1 && ((e0 & e1) != 2'b00);
    if (!clash) return {v1, v0};
    return p ? 2'b10 : 2'b01;
  endfunction

  always @(negedge reset) begin
    m_q    = 16'h0000;
    m_prio = 1'b0;
  end

  // Model state advances on each accepted edge.
  always @(posedge clk) begin
    logic [1:0] g;
    logic [15:0] nq;
    if (reset) begin
      g  = grants(req0_val, req1_val, req0_en, req1_en, m_prio);
      nq = m_q;
      for (int l = 0; l < 2; l++) begin
        if (g[0] && req0_en[l]) nq[l*8 +: 8] = req0_d[l*8 +: 8];
        else if (g[1] && req1_en[l]) nq[l*8 +: 8] = req1_d[l*8 +: 8];
      end
      if (g == 2'b01 && req1_val) m_prio = 1'b1;
      else if (g == 2'b10 && req0_val) m_prio = 1'b0;
      m_q = nq;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [1:0] g;
    if (!reset) g = 2'b00;
    else g = grants(req0_val, req1_val, req0_en, req1_en, m_prio);
    chk("cyc_rdy0", {15'd0, req0_rdy}, {15'd0, g[0]});
    chk("cyc_rdy1", {15'd0, req1_rdy}, {15'd0, g[1]});
    chk("cyc_q", q, m_q);
    chk("cyc_prio", {15'd0, prio}, {15'd0, m_prio});
  end

  task automatic apply(input logic v0, input logic [1:0] e0, input logic [15:0] d0,
                       input logic v1, input logic [1:0] e1, input logic [15:0] d1,
                       input logic x0, input logic x1);
    req0_val = v0; req0_en = e0; req0_d = d0;
    req1_val = v1; req1_en = e1; req1_d = d1;
    #2;
    chk("dir_rdy0", {15'd0, req0_rdy}, {15'd0, x0});
    chk("dir_rdy1", {15'd0, req1_rdy}, {15'd0, x1});
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req0_val = 1'b0; req0_en = 2'b00; req0_d = 16'h0000;
    req1_val = 1'b0; req1_en = 2'b00; req1_d = 16'h0000;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    @(negedge clk); #1;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    req0_val = 1'b1; req0_en = 2'b11; req0_d = 16'hffff;
    #3;
    chk("rst_rdy0", {15'd0, req0_rdy}, 16'd0);
    chk("rst_q", q, 16'h0000);
    chk("rst_prio", {15'd0, prio}, 16'd0);
    idle_inputs();
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;

    // Single requester
    apply(1, 2'b11, 16'h4567, 0, 2'b00, 16'h0000, 1, 0);
    chk("single_q", q, 16'h4567);
    chk("single_prio", {15'd0, prio}, 16'd0);
    apply(1, 2'b10, 16'h89ab, 0, 2'b00, 16'h0000, 1, 0);
    chk("single_hi_q", q, 16'h8967);

    // Disjoint merge from q = 0
    apply(1, 2'b11, 16'h0000, 0, 2'b00, 16'h0000, 1, 0);
    chk("clear_q", q, 16'h0000);
    apply(1, 2'b01, 16'h00cd, 1, 2'b10, 16'hef00, 1, 1);
    chk("merge_q", q, 16'hefcd);
    chk("merge_prio", {15'd0, prio}, 16'd0);

    // Conflict round-robin
    apply(1, 2'b11, 16'h1111, 1, 2'b11, 16'h2222, 1, 0);
    chk("conf1_q", q, 16'h1111);
    chk("conf1_prio", {15'd0, prio}, 16'd1);
    apply(0, 2'b11, 16'h1111, 1, 2'b11, 16'h2222, 0, 1);
    chk("conf2_q", q, 16'h2222);
    chk("conf2_prio", {15'd0, prio}, 16'd1);

    // Alternation from prio = 0
    pulse_reset();
    chk("pulse_q", q, 16'h0000);
    chk("pulse_prio", {15'd0, prio}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      logic w0;
      w0 = (i % 2 == 0);
      apply(1, 2'b01, 16'h0011, 1, 2'b01, 16'h0022, w0, !w0);
      chk("alt_q", q, w0 ? 16'h0011 : 16'h0022);
      chk("alt_prio", {15'd0, prio}, {15'd0, w0});
    end

    // Zero-enable and idle
    apply(1, 2'b00, 16'hffff, 1, 2'b11, 16'h3c5a, 1, 1);
    chk("zero_q", q, 16'h3c5a);
    chk("zero_prio", {15'd0, prio}, 16'd0);
    apply(0, 2'b00, 16'h0000, 0, 2'b00, 16'h0000, 0, 0);
    chk("idle_q", q, 16'h3c5a);

    // Asynchronous reset mid-stream
    apply(1, 2'b11, 16'hcdef, 1, 2'b11, 16'h1234, 1, 0);
    chk("pre_rst_q", q, 16'hcdef);
    chk("pre_rst_prio", {15'd0, prio}, 16'd1);
    req0_val = 1'b1; req1_val = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_q", q, 16'h0000);
    chk("arst_prio", {15'd0, prio}, 16'd0);
    chk("arst_rdy0", {15'd0, req0_rdy}, 16'd0);
    chk("arst_rdy1", {15'd0, req1_rdy}, 16'd0);
    idle_inputs();
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;
    apply(0, 2'b00, 16'h0000, 1, 2'b11, 16'h0201, 0, 1);
    chk("post_rst_q", q, 16'h0201);

    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/byte_reg_arbiter.md
# byte_reg_arbiter

Two-port write arbiter in front of a 16-bit register with per-byte write enables. It shares the register between two requesters and serialises their byte writes with round-robin fairness. When the two requests touch disjoint byte lanes, both are merged and written in the same cycle. The block sits wherever two producers update one byte-addressable control/status register, and it owns that register.

## Interface
- No parameters; the data width is fixed at 16 bits (2 byte lanes).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_val  input  1  requester 0 has a write pending.
- req0_rdy  output  1  requester 0 write accepted this cycle.
- req0_en  input  2  requester 0 byte enables; bit i selects byte i, i.e. bits [8i+7:8i].
- req0_d  input  16  requester 0 write data.
- req1_val  input  1  requester 1 has a write pending.
- req1_rdy  output  1  requester 1 write accepted this cycle.
- req1_en  input  2  requester 1 byte enables.
- req1_d  input  16  requester 1 write data.
- q  output  16  register contents.
- prio  output  1  current round-robin priority holder: 0 = requester 0, 1 = requester 1.

## Operation
- **Handshake:** a write transfers in a cycle where val and rdy are both 1.
  - rdy is combinational from both val inputs, both en inputs, prio and reset.
  - rdy is 0 whenever val is 0.
  - rdy is 0 while reset is asserted (low).
- **Conflict:** a conflict exists when req0_val, req1_val and (req0_en & req1_en) != 0 are all true.
- **Grant rules:**
  - Only one val high: that requester gets rdy = 1.
  - Both val high, no conflict: both get rdy = 1. Each byte lane is written by whichever requester enables it; lanes enabled by neither hold their value.
  - Conflict: only the requester selected by prio gets rdy = 1. The other sees rdy = 0 and must hold val, en and d stable until accepted.
- **Priority update:** prio changes only on a conflict cycle. It takes the index of the requester that lost that cycle.
  - Non-conflicting cycles leave prio unchanged, whether the grant was single or merged.
- **Zero-enable request:** a request with en = 2'b00 is accepted normally.
  - It is a no-op on q.
  - It can never cause a conflict.
- **Register update:** for each byte i, q byte i takes the d byte of the granted requester enabling lane i. Otherwise it holds.
- **Reset:** asserting reset asynchronously forces q = 16'h0000 and prio = 0.
  - This holds even mid-operation; any write in flight that cycle is discarded.
  - After deassertion, the first rising edge may already accept writes.

## Timing
- A write accepted in cycle N is visible on q after the rising edge that ends cycle N (1-cycle latency).
- rdy is valid in the same cycle as val; there is no request buffering.
- In a conflict, the losing requester is granted no later than the next cycle in which it is still valid. Worst-case wait is 1 cycle.
- prio updates on the same edge as the q write of the conflict cycle.
- Reset values: q = 16'h0000, prio = 0, req0_rdy = 0, req1_rdy = 0.

## Test plan
- **Single requester:**
  - Stimulus: after reset, req0_val = 1, en = 2'b11, d = 16'h4567.
  - Required: req0_rdy = 1; next cycle q = 16'h4567 and prio = 0.
  - Then en = 2'b10, d = 16'h89ab gives q = 16'h8967.
- **Disjoint merge:**
  - Stimulus: q = 16'h0000; req0 en = 2'b01, d = 16'h00cd; req1 en = 2'b10, d = 16'hef00, both in the same cycle.
  - Required: both rdy = 1; next q = 16'hefcd; prio unchanged at 0.
- **Conflict round-robin:**
  - Stimulus: both requesters valid with en = 2'b11 and held; req0 d = 16'h1111, req1 d = 16'h2222.
  - Required, cycle 1: req0_rdy = 1, req1_rdy = 0, q becomes 16'h1111, prio becomes 1.
  - Required, cycle 2 (req0 drops val): req1_rdy = 1, q becomes 16'h2222, prio stays 1 (no conflict).
- **Alternation:**
  - Stimulus: both requesters continuously valid, en = 2'b01, for 4 cycles.
  - Required: grants alternate 0, 1, 0, 1, and prio toggles every cycle.
- **Zero-enable and idle:**
  - Stimulus: req0 en = 2'b00 together with req1 en = 2'b11.
  - Required: both accepted (no conflict), and q equals req1_d.
  - Stimulus: neither val high. Required: q holds and both rdy = 0.
- **Asynchronous reset mid-stream:**
  - Stimulus: with q = 16'hcdef and prio = 1, pull reset low between clock edges.
  - Required: q = 16'h0000, prio = 0 and both rdy = 0 immediately, before any edge.
  - After release, a single req1 write of 16'h0201 gives q = 16'h0201 one cycle later.
